platform_grid_scheduler: RTL and testbench

Owns the tiled platform field for the VGA game layer. It holds a per-tile occupancy map and scrolls the field downward once per frame. When a full tile height has been scrolled, it shifts in a new pseudo-random top row. It clears tiles hit by the player and issues the per-pixel platform drawingRequest consumed by the object mux.

---
 rtl/platform_grid_scheduler.sv | 152 +++++++++++++++
 tb/tb_platform_grid_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_grid_scheduler.sv
// Tiled platform field: occupancy map, per-frame downward scroll, LFSR-fed new rows,
// hit clearing and the registered per-pixel platform drawing request.
module platform_grid_scheduler #(
    parameter int          TILE_W      = 90,
    parameter int          TILE_H      = 90,
    parameter int          COLS        = 8,
    parameter int          ROWS        = 6,
    parameter int          PLAT_X      = 10,
    parameter int          PLAT_W      = 60,
    parameter int          PLAT_Y      = 80,
    parameter int          PLAT_H      = 10,
    parameter int          SCROLL_STEP = 1,
    parameter logic [7:0]  INIT_ROW    = 8'h55
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        scrollEnable,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        collision,
    output logic        drawingRequest,
    output logic [6:0]  scrollOffset,
    output logic        busy,
    output logic        rowShiftPulse,
    output logic        hitPulse,
    output logic [7:0]  hitCount
);

    typedef enum logic [1:0] {IDLE, SCROLL, SHIFT} state_e;

    localparam logic [10:0] TILE_W_L = 11'(TILE_W);
    localparam logic [10:0] TILE_H_L = 11'(TILE_H);
    localparam logic [10:0] COLS_L   = 11'(COLS);
    localparam logic [10:0] ROWS_L   = 11'(ROWS);
    localparam logic [10:0] PX_LO    = 11'(PLAT_X);
    localparam logic [10:0] PX_HI    = 11'(PLAT_X + PLAT_W);
    localparam logic [10:0] PY_LO    = 11'(PLAT_Y);
    localparam logic [10:0] PY_HI    = 11'(PLAT_Y + PLAT_H);
    localparam logic [7:0]  TILE_H_8 = 8'(TILE_H);
    localparam logic [7:0]  STEP_8   = 8'(SCROLL_STEP);

    state_e            state_q, state_d;
    logic [COLS-1:0]   rows_q [ROWS];
    logic [COLS-1:0]   rows_d [ROWS];
    logic [6:0]        scroll_q, scroll_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [7:0]        hit_count_q, hit_count_d;
    logic              draw_q, busy_q, shift_pulse_q, hit_pulse_q;
    logic              busy_d, shift_pulse_d;

    logic [10:0] y_eff, row, col, local_x, local_y;
    logic        occupied, draw, hit, accept, wrap;
    logic [7:0]  sum;
    logic [COLS-1:0] new_row;

    // Pixel decode shared by the draw request and the hit logic.
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        y_eff    = pixelY - {4'b0, scroll_q};
        row      = y_eff / TILE_H_L;
        local_y  = y_eff % TILE_H_L;
        col      = pixelX / TILE_W_L;
        local_x  = pixelX % TILE_W_L;
        occupied = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (row == 11'(r) && col == 11'(c)) occupied = rows_q[r][c];
            end
        end
        draw = (pixelY >= {4'b0, scroll_q}) && (col < COLS_L) && (row < ROWS_L) && occupied
            && (local_x >= PX_LO) && (local_x < PX_HI)
            && (local_y >= PY_LO) && (local_y < PY_HI);
    end

    assign accept = (state_q == IDLE) && !busy_q && startOfFrame && scrollEnable;
    assign hit    = (state_q == IDLE) && collision && draw;
    assign sum    = {1'b0, scroll_q} + STEP_8;
    assign wrap   = (sum >= TILE_H_8);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCROLL;
            SCROLL:  state_d = wrap ? SHIFT : IDLE;
            SHIFT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rows_d        = rows_q;
        scroll_d      = scroll_q;
        lfsr_d        = lfsr_q;
        hit_count_d   = hit_count_q;
        busy_d        = (state_q != IDLE);
        shift_pulse_d = (state_q == SHIFT);
        new_row       = lfsr_q[COLS-1:0];
        case (state_q)
            SCROLL: scroll_d = wrap ? 7'(sum - TILE_H_8) : sum[6:0];
            SHIFT: begin
                for (int r = ROWS - 1; r >= 1; r--) rows_d[r] = rows_q[r-1];
                // An all-zero row would leave the player nothing to land on.
                rows_d[0] = (new_row == '0) ? COLS'(1) : new_row;
                lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end
            default: begin
                if (hit) begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            if (row == 11'(r) && col == 11'(c)) rows_d[r][c] = 1'b0;
                        end
                    end
                    if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q       <= IDLE;
            for (int r = 0; r < ROWS; r++) rows_q[r] <= INIT_ROW[COLS-1:0];
            scroll_q      <= '0;
            lfsr_q        <= 8'hA5;
            hit_count_q   <= '0;
            draw_q        <= 1'b0;
            busy_q        <= 1'b0;
            shift_pulse_q <= 1'b0;
            hit_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rows_q        <= rows_d;
            scroll_q      <= scroll_d;
            lfsr_q        <= lfsr_d;
            hit_count_q   <= hit_count_d;
            draw_q        <= draw;
            busy_q        <= busy_d;
            shift_pulse_q <= shift_pulse_d;
            hit_pulse_q   <= hit;
        end
    end

    assign drawingRequest = draw_q;
    assign scrollOffset   = scroll_q;
    assign busy           = busy_q;
    assign rowShiftPulse  = shift_pulse_q;
    assign hitPulse       = hit_pulse_q;
    assign hitCount       = hit_count_q;

endmodule

// File: tb/tb_platform_grid_scheduler.sv
// Self-checking bench for platform_grid_scheduler: directed scenarios followed by
// randomized frames, pixel probes and collisions against an arithmetic field model.
module tb_platform_grid_scheduler;

    logic        clk = 1'b0;
    logic        resetN, startOfFrame, scrollEnable, collision;
    logic [10:0] pixelX, pixelY;
    logic        drawingRequest, busy, rowShiftPulse, hitPulse;
    logic [6:0]  scrollOffset;
    logic [7:0]  hitCount;

    platform_grid_scheduler dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .scrollEnable   (scrollEnable),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .collision      (collision),
        .drawingRequest (drawingRequest),
        .scrollOffset   (scrollOffset),
        .busy           (busy),
        .rowShiftPulse  (rowShiftPulse),
        .hitPulse       (hitPulse),
        .hitCount       (hitCount)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_shift_seen = 0;

    // Reference field: occupancy per row, scroll in pixels, LFSR value, hit total.
    int m_rows [6];
    int m_scroll, m_lfsr, m_hits;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int r = 0; r < 6; r++) m_rows[r] = 'h55;
        m_scroll = 0;
        m_lfsr   = 'hA5;
        m_hits   = 0;
    endfunction

    function automatic void m_shift();
        int fb;
        for (int r = 5; r >= 1; r--) m_rows[r] = m_rows[r-1];
        m_rows[0] = ((m_lfsr & 255) == 0) ? 1 : (m_lfsr & 255);
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 255;
    endfunction

    function automatic int m_draw(input int x, input int y);
        int ye, row, col, lx, ly;
        if (y < m_scroll) return 0;
        ye  = y - m_scroll;
        row = ye / 90;
        ly  = ye % 90;
        col = x / 90;
        lx  = x % 90;
        if (col >= 8 || row >= 6) return 0;
        if (((m_rows[row] >> col) & 1) == 0) return 0;
        return (lx >= 10 && lx < 70 && ly >= 80 && ly < 90) ? 1 : 0;
    endfunction

    task automatic do_reset();
        resetN = 1'b0; startOfFrame = 1'b0; scrollEnable = 1'b0; collision = 1'b0;
        pixelX = '0; pixelY = '0;
        tick; tick;
        resetN = 1'b1;
        m_reset();
    endtask

    task automatic pix(input int x, input int y, input int exp, input string tag);
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick;
        check(tag, 32'(drawingRequest), exp);
    endtask

    // mode 0: plain frame, 1: collision during SHIFT, 2: reset during SHIFT, 3: startOfFrame held two cycles
    task automatic frame(input bit en, input int mode);
        int wrap, exp_scroll;
        wrap = 0;
        if (en) begin
            m_scroll += 1;
            if (m_scroll >= 90) begin m_scroll -= 90; wrap = 1; end
        end
        exp_scroll   = m_scroll;
        startOfFrame = 1'b1;
        scrollEnable = en;
        tick;
        if (mode != 3) startOfFrame = 1'b0;
        tick;
        startOfFrame = 1'b0;
        check("busy_n1", 32'(busy), 32'(en));
        check("scroll_n1", 32'(scrollOffset), exp_scroll);
        if (mode == 1) collision = 1'b1;
        if (mode == 2) resetN = 1'b0;
        tick;
        collision = 1'b0;
        if (mode == 2) begin
            resetN = 1'b1;
            m_reset();
            wrap = 0;
        end else if (wrap != 0) begin
            m_shift();
        end
        if (rowShiftPulse) n_shift_seen++;
        check("shift_pulse", 32'(rowShiftPulse), wrap);
        check("busy_n2", 32'(busy), wrap);
        if (mode == 1) check("hit_in_shift", 32'(hitPulse), 0);
        tick;
        check("shift_pulse_n3", 32'(rowShiftPulse), 0);
        check("busy_n3", 32'(busy), 0);
        check("scroll_end", 32'(scrollOffset), m_scroll);
        check("hit_count_frame", 32'(hitCount), m_hits);
    endtask

    task automatic hit(input int x, input int y, input string tag);
        int exp, row, col;
        exp = m_draw(x, y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        collision = 1'b1;
        tick;
        collision = 1'b0;
        if (exp != 0) begin
            row = (y - m_scroll) / 90;
            col = x / 90;
            m_rows[row] &= ~(1 << col);
            if (m_hits < 255) m_hits++;
        end
        check({tag, "_pulse"}, 32'(hitPulse), exp);
        check({tag, "_count"}, 32'(hitCount), m_hits);
        tick;
        check({tag, "_pulse_end"}, 32'(hitPulse), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_draw", 32'(drawingRequest), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_scroll", 32'(scrollOffset), 0);
        check("rst_shift", 32'(rowShiftPulse), 0);
        check("rst_hit", 32'(hitPulse), 0);
        check("rst_count", 32'(hitCount), 0);

        pix(10, 80, 1, "p_10_80");
        pix(69, 89, 1, "p_69_89");
        pix(70, 80, 0, "p_70_80");
        pix(100, 80, 0, "p_100_80");

        for (int i = 0; i < 3; i++) frame(1'b1, 0);
        check("scroll3", 32'(scrollOffset), 3);
        pix(10, 83, 1, "s3_10_83");
        pix(10, 82, 0, "s3_10_82");
        pix(10, 2, 0, "s3_10_2");

        do_reset();
        n_shift_seen = 0;
        for (int i = 0; i < 90; i++) frame(1'b1, 0);
        check("shift_count90", n_shift_seen, 1);
        check("scroll90", 32'(scrollOffset), 0);
        pix(10, 80, 1, "r0a5_c0");
        pix(100, 80, 0, "r0a5_c1");
        pix(190, 80, 1, "r0a5_c2");
        for (int i = 0; i < 90; i++) frame(1'b1, 0);
        pix(10, 80, 0, "r04a_c0");
        pix(100, 80, 1, "r04a_c1");

        do_reset();
        hit(20, 85, "hit1");
        check("hit1_total", 32'(hitCount), 1);
        pix(20, 85, 0, "hit1_cleared");
        hit(100, 85, "hit_empty");
        check("hit_empty_total", 32'(hitCount), 1);

        do_reset();
        for (int i = 0; i < 89; i++) frame(1'b1, 0);
        pix(10, 169, 1, "pre_shift_target");
        frame(1'b1, 1);
        check("shift_drop_total", 32'(hitCount), 0);
        for (int i = 0; i < 89; i++) frame(1'b1, 0);
        frame(1'b1, 2);
        check("rst_shift_scroll", 32'(scrollOffset), 0);
        pix(10, 80, 1, "rst_shift_c0");
        pix(100, 80, 0, "rst_shift_c1");
        for (int i = 0; i < 90; i++) frame(1'b1, 0);
        pix(100, 80, 0, "lfsr_reseed_c1");
        pix(190, 80, 1, "lfsr_reseed_c2");

        do_reset();
        pix(725, 80, 0, "col8");
        pix(10, 620, 0, "row6");
        pix(10, 530, 1, "row5");
        pix(550, 80, 1, "col6");
        pix(640, 80, 0, "col7");
        frame(1'b1, 3);
        check("busy_ignore_scroll", 32'(scrollOffset), 1);
        frame(1'b0, 0);
        check("disabled_scroll", 32'(scrollOffset), 1);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            int op, x, y;
            op = int'($urandom_range(9, 0));
            if ($urandom_range(1, 0) == 1) begin
                x = int'($urandom_range(8, 0)) * 90 + int'($urandom_range(89, 0));
                y = m_scroll + int'($urandom_range(6, 0)) * 90 + int'($urandom_range(89, 70));
            end else begin
                x = int'($urandom_range(799, 0));
                y = int'($urandom_range(649, 0));
            end
            if (op < 4)      frame($urandom_range(4, 0) != 0, 0);
            else if (op < 7) pix(x, y, m_draw(x, y), "rnd_pix");
            else             hit(x, y, "rnd_hit");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
